trigger_event_fifo: RTL and testbench

TRIGGER_EVENT_FIFO -- requirements
Module: trigger_event_fifo

---
 rtl/dynode_trig_pkg.sv | 20 ++
 rtl/brorpl.sv | 15 +
 rtl/trig_fifo.sv | 63 ++++++
 rtl/trigger_event_fifo.sv | 102 ++++++++++
 tb/tb_trigger_event_fifo.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/dynode_trig_pkg.sv
// Shared constants for the trigger event FIFO: register offsets, entry field widths, bus layout.
package dynode_trig_pkg;
  localparam int ENTRY_W  = 32;
  localparam int COARSE_W = 26;
  localparam int OFFSET_W = 6;

  localparam logic [15:0] REG_STATUS  = 16'd0;
  localparam logic [15:0] REG_HEAD_LO = 16'd1;
  localparam logic [15:0] REG_HEAD_HI = 16'd2;
  localparam logic [15:0] REG_POP     = 16'd3;
  localparam logic [15:0] REG_CTRL    = 16'd4;
  localparam logic [15:0] REG_DROP    = 16'd5;

  typedef struct packed {
    logic        clk;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wrdata;
  } ibus_t;
endpackage

// File: rtl/brorpl.sv
// Bus read-only register: decodes one address and contributes its data to an AND-OR read bus.
module brorpl #(
  parameter logic [15:0] ADDR = 16'h0000
) (
  input  logic [33:0] ibus,
  input  logic [15:0] din,
  output logic [15:0] obus,
  output logic        hit
);
  logic unused_bus;
  assign unused_bus = ^{ibus[33:32], ibus[15:0]};

  assign hit  = (ibus[31:16] == ADDR);
  assign obus = hit ? din : 16'h0000;
endmodule

// File: rtl/trig_fifo.sv
// Synchronous FIFO with flush; head is the oldest entry, count spans 0..DEPTH.
module trig_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [W-1:0]            din,
  output logic [W-1:0]            head,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty,
  output logic                    nonempty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count_nxt;
  logic          pop_eff, push_eff;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_eff  = pop & ~empty;
  // a full FIFO still accepts a push when a pop frees the slot in the same cycle
  assign push_eff = push & (~full | pop_eff);
  assign head     = mem[rptr];

  always_comb begin
    count_nxt = count;
    case ({push_eff, pop_eff})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk)
    if (push_eff) mem[wptr] <= din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      nonempty <= 1'b0;
    end else if (flush) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      nonempty <= 1'b0;
    end else begin
      if (push_eff) wptr <= wptr + AW'(1);
      if (pop_eff)  rptr <= rptr + AW'(1);
      count    <= count_nxt;
      nonempty <= (count_nxt != '0);
    end
  end
endmodule

// File: rtl/trigger_event_fifo.sv
// Timestamps rising edges of the dynode trigger into a FIFO readable over the register bus.
module trigger_event_fifo
  import dynode_trig_pkg::*;
#(
  parameter logic [15:0] BASE  = 16'h0040,
  parameter int          DEPTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [33:0]         ibus,
  output logic [15:0]         obus,
  input  logic                single,
  input  logic [OFFSET_W-1:0] offset,
  output logic                nonempty
);
  localparam int CW = $clog2(DEPTH) + 1;

  ibus_t bus;
  assign bus = ibus;

  logic unused_clk;
  assign unused_clk = bus.clk;

  logic                enable, prev_single, overflow;
  logic [COARSE_W-1:0] coarse;
  logic [15:0]         drop_cnt;
  logic [ENTRY_W-1:0]  last_pop, fifo_head, head_rd;
  logic [CW-1:0]       count;
  logic                full, empty;
  logic                wr_pop, ctrl_wr, clr, trig, drop;

  assign wr_pop  = bus.wr && (bus.addr == BASE + REG_POP);
  assign ctrl_wr = bus.wr && (bus.addr == BASE + REG_CTRL);
  assign clr     = ctrl_wr & bus.wrdata[1];
  // a clear wins over a coincident trigger: the event is neither stored nor counted
  assign trig    = single & ~prev_single & enable & ~clr;
  assign drop    = trig & full & ~wr_pop;

  trig_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push     (trig),
    .pop      (wr_pop),
    .flush    (clr),
    .din      ({coarse, offset}),
    .head     (fifo_head),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .nonempty (nonempty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable      <= 1'b0;
      prev_single <= 1'b0;
      coarse      <= '0;
      overflow    <= 1'b0;
      drop_cnt    <= '0;
      last_pop    <= '0;
    end else begin
      prev_single <= single;
      if (ctrl_wr) enable <= bus.wrdata[0];
      if (clr) begin
        coarse   <= '0;
        overflow <= 1'b0;
        drop_cnt <= '0;
        last_pop <= '0;
      end else begin
        coarse <= coarse + COARSE_W'(1);
        if (drop) begin
          overflow <= 1'b1;
          if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
        if (wr_pop && !empty) last_pop <= fifo_head;
      end
    end
  end

  // an empty FIFO presents the most recently popped entry
  assign head_rd = empty ? last_pop : fifo_head;

  logic [3:0]       ro_hit;
  logic [3:0][15:0] ro_rd;

  brorpl #(.ADDR(BASE + REG_STATUS)) u_stat (
    .ibus(ibus), .din({8'b0, 7'(count), overflow}), .obus(ro_rd[0]), .hit(ro_hit[0]));
  brorpl #(.ADDR(BASE + REG_HEAD_LO)) u_hlo (
    .ibus(ibus), .din(head_rd[15:0]), .obus(ro_rd[1]), .hit(ro_hit[1]));
  brorpl #(.ADDR(BASE + REG_HEAD_HI)) u_hhi (
    .ibus(ibus), .din(head_rd[31:16]), .obus(ro_rd[2]), .hit(ro_hit[2]));
  brorpl #(.ADDR(BASE + REG_DROP)) u_drop (
    .ibus(ibus), .din(drop_cnt), .obus(ro_rd[3]), .hit(ro_hit[3]));

  logic        ctrl_hit;
  logic [15:0] ctrl_rd;
  assign ctrl_hit = (bus.addr == BASE + REG_CTRL);
  assign ctrl_rd  = ctrl_hit ? {15'b0, enable} : 16'h0000;

  assign obus = (|ro_hit || ctrl_hit) ?
                (ro_rd[0] | ro_rd[1] | ro_rd[2] | ro_rd[3] | ctrl_rd) : 16'hzzzz;
endmodule

// File: tb/tb_trigger_event_fifo.sv
// Directed bench for trigger_event_fifo: register map, edge detect, overflow, collisions, async reset.
module tb_trigger_event_fifo;
  localparam logic [15:0] A_STAT = 16'h0040;
  localparam logic [15:0] A_HLO  = 16'h0041;
  localparam logic [15:0] A_HHI  = 16'h0042;
  localparam logic [15:0] A_POP  = 16'h0043;
  localparam logic [15:0] A_CTRL = 16'h0044;
  localparam logic [15:0] A_DROP = 16'h0045;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr;
  logic [15:0] addr, wdata;
  logic        single;
  logic [5:0]  offset;
  logic [33:0] ibus;
  wire  [15:0] obus;
  wire         nonempty;

  int total = 0;
  int pass  = 0;
  logic [15:0] v, v2;
  logic [31:0] e;

  assign ibus = {clk, wr, addr, wdata};
  always #5 clk = ~clk;

  trigger_event_fifo #(.BASE(16'h0040), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .ibus(ibus), .obus(obus),
    .single(single), .offset(offset), .nonempty(nonempty));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [15:0] a, input logic [15:0] d);
    addr = a; wdata = d; wr = 1'b1;
    cyc();
    wr = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    addr = a;
    #1;
    d = obus;
  endtask

  task automatic pulse(input logic [5:0] o);
    single = 1'b1; offset = o;
    cyc();
    single = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    reset = 1'b0; wr = 1'b0; addr = A_STAT; wdata = '0; single = 1'b0; offset = '0;
    #2;
    total++; if (nonempty !== 1'b0) $display("FAIL rst_nonempty got=%b exp=0", nonempty); else pass++;
    rd(A_STAT, v);
    total++; if (v !== 16'h0000) $display("FAIL rst_status got=%h exp=0000", v); else pass++;
    rd(A_CTRL, v);
    total++; if (v !== 16'h0000) $display("FAIL rst_ctrl got=%h exp=0000", v); else pass++;
    rd(A_DROP, v);
    total++; if (v !== 16'h0000) $display("FAIL rst_drop got=%h exp=0000", v); else pass++;
    reset = 1'b1;
    cyc();
    wr_reg(A_POP, 16'h1234);
    rd(A_STAT, v);
    total++; if (v !== 16'h0000) $display("FAIL pop_empty_status got=%h exp=0000", v); else pass++;
    rd(A_HLO, v);
    total++; if (v !== 16'h0000) $display("FAIL pop_empty_head got=%h exp=0000", v); else pass++;
  endtask

  task automatic test_single();
    wr_reg(A_CTRL, 16'h0003);
    repeat (100) cyc();
    pulse(6'd37);
    rd(A_STAT, v);
    total++; if (v !== 16'h0002) $display("FAIL single_status got=%h exp=0002", v); else pass++;
    rd(A_HLO, v);
    total++; if (v !== 16'h1925) $display("FAIL single_head_lo got=%h exp=1925", v); else pass++;
    rd(A_HHI, v);
    total++; if (v !== 16'h0000) $display("FAIL single_head_hi got=%h exp=0000", v); else pass++;
    total++; if (nonempty !== 1'b1) $display("FAIL single_nonempty got=%b exp=1", nonempty); else pass++;
    rd(A_CTRL, v);
    total++; if (v !== 16'h0001) $display("FAIL ctrl_readback got=%h exp=0001", v); else pass++;
  endtask

  task automatic test_edge();
    wr_reg(A_CTRL, 16'h0003);
    single = 1'b1; offset = 6'd5;
    repeat (5) cyc();
    single = 1'b0;
    cyc();
    rd(A_STAT, v);
    total++; if (v !== 16'h0002) $display("FAIL edge_status got=%h exp=0002", v); else pass++;
    rd(A_HLO, v);
    total++; if (v !== 16'h0005) $display("FAIL edge_head_lo got=%h exp=0005", v); else pass++;
  endtask

  task automatic test_overflow();
    wr_reg(A_CTRL, 16'h0003);
    for (int i = 0; i < 20; i++) pulse(6'(i));
    rd(A_STAT, v);
    total++; if (v !== 16'h0021) $display("FAIL ovf_status got=%h exp=0021", v); else pass++;
    rd(A_DROP, v);
    total++; if (v !== 16'h0004) $display("FAIL ovf_drop got=%h exp=0004", v); else pass++;
    for (int i = 0; i < 16; i++) begin
      rd(A_HLO, v); rd(A_HHI, v2);
      e = {26'(2 * i), 6'(i)};
      total++; if ({v2, v} !== e) $display("FAIL ovf_pop%0d got=%h exp=%h", i, {v2, v}, e); else pass++;
      wr_reg(A_POP, 16'h0000);
    end
    rd(A_STAT, v);
    total++; if (v !== 16'h0001) $display("FAIL ovf_drained_status got=%h exp=0001", v); else pass++;
    total++; if (nonempty !== 1'b0) $display("FAIL ovf_nonempty got=%b exp=0", nonempty); else pass++;
    rd(A_HLO, v); rd(A_HHI, v2);
    total++; if ({v2, v} !== 32'h0000_078F) $display("FAIL empty_last_pop got=%h exp=0000078f", {v2, v}); else pass++;
  endtask

  task automatic test_full_pushpop();
    wr_reg(A_CTRL, 16'h0003);
    for (int i = 0; i < 16; i++) pulse(6'(i));
    single = 1'b1; offset = 6'h2A; addr = A_POP; wdata = '0; wr = 1'b1;
    cyc();
    wr = 1'b0; single = 1'b0;
    cyc();
    rd(A_STAT, v);
    total++; if (v !== 16'h0020) $display("FAIL pp_status got=%h exp=0020", v); else pass++;
    rd(A_DROP, v);
    total++; if (v !== 16'h0000) $display("FAIL pp_drop got=%h exp=0000", v); else pass++;
    rd(A_HLO, v); rd(A_HHI, v2);
    total++; if ({v2, v} !== 32'h0000_0081) $display("FAIL pp_head got=%h exp=00000081", {v2, v}); else pass++;
    repeat (15) wr_reg(A_POP, 16'h0000);
    rd(A_HLO, v); rd(A_HHI, v2);
    total++; if ({v2, v} !== 32'h0000_082A) $display("FAIL pp_tail got=%h exp=0000082a", {v2, v}); else pass++;
    rd(A_STAT, v);
    total++; if (v !== 16'h0002) $display("FAIL pp_last_status got=%h exp=0002", v); else pass++;
  endtask

  task automatic test_clear_collision();
    for (int i = 0; i < 17; i++) pulse(6'(i));
    rd(A_DROP, v);
    total++; if (v !== 16'h0002) $display("FAIL cc_pre_drop got=%h exp=0002", v); else pass++;
    single = 1'b1; offset = 6'd3; addr = A_CTRL; wdata = 16'h0003; wr = 1'b1;
    cyc();
    wr = 1'b0; single = 1'b0;
    rd(A_STAT, v);
    total++; if (v !== 16'h0000) $display("FAIL cc_status got=%h exp=0000", v); else pass++;
    rd(A_DROP, v);
    total++; if (v !== 16'h0000) $display("FAIL cc_drop got=%h exp=0000", v); else pass++;
    total++; if (nonempty !== 1'b0) $display("FAIL cc_nonempty got=%b exp=0", nonempty); else pass++;
    repeat (9) cyc();
    pulse(6'd1);
    rd(A_HLO, v);
    total++; if (v !== 16'h0241) $display("FAIL cc_coarse_restart got=%h exp=0241", v); else pass++;
  endtask

  task automatic test_disable();
    wr_reg(A_CTRL, 16'h0002);
    pulse(6'd9);
    rd(A_STAT, v);
    total++; if (v !== 16'h0000) $display("FAIL dis_status got=%h exp=0000", v); else pass++;
    rd(A_DROP, v);
    total++; if (v !== 16'h0000) $display("FAIL dis_drop got=%h exp=0000", v); else pass++;
    wr_reg(A_CTRL, 16'h0001);
    pulse(6'd4);
    rd(A_HLO, v);
    total++; if (v !== 16'h00C4) $display("FAIL dis_coarse_runs got=%h exp=00c4", v); else pass++;
  endtask

  task automatic test_async_reset();
    total++; if (nonempty !== 1'b1) $display("FAIL ar_pre_nonempty got=%b exp=1", nonempty); else pass++;
    addr = A_STAT;
    #2 reset = 1'b0;
    #1;
    total++; if (nonempty !== 1'b0) $display("FAIL ar_nonempty got=%b exp=0", nonempty); else pass++;
    total++; if (obus !== 16'h0000) $display("FAIL ar_status got=%h exp=0000", obus); else pass++;
    addr = A_CTRL;
    #1;
    total++; if (obus !== 16'h0000) $display("FAIL ar_enable got=%h exp=0000", obus); else pass++;
    reset = 1'b1;
    cyc();
    pulse(6'd7);
    rd(A_STAT, v);
    total++; if (v !== 16'h0000) $display("FAIL ar_post_status got=%h exp=0000", v); else pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_edge();
    test_overflow();
    test_full_pushpop();
    test_clear_collision();
    test_disable();
    test_async_reset();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
